prefix_adder_pipe: RTL and testbench

PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

---
 rtl/prefix_adder_pkg.sv | 16 +
 rtl/gp_combine.sv | 14 +
 rtl/prefix_adder_pipe.sv | 131 +++++++++++++
 tb/tb_prefix_adder_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and parameters for the pipelined Kogge-Stone prefix adder.
`timescale 1ns/1ps
package prefix_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int tree_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/gp_combine.sv
// Prefix combine node: merges a more significant span (hi) with a less significant one (lo).
`timescale 1ns/1ps
module gp_combine
  import prefix_adder_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t res
);

  assign res.g = hi.g | (hi.p & lo.g);
  assign res.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Three-stage pipelined Kogge-Stone adder with a single global stall (valid/ready on both sides).
`timescale 1ns/1ps
module prefix_adder_pipe
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int LEVELS = tree_levels(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_g,
  output logic             grp_p
);

  logic advance;

  logic             valid1_reg;
  logic [WIDTH-1:0] g1_reg;
  logic [WIDTH-1:0] p1_reg;
  logic             cin1_reg;

  logic             valid2_reg;
  logic [WIDTH-1:0] gpre2_reg;
  logic [WIDTH-1:0] ppre2_reg;
  logic [WIDTH-1:0] p2_reg;
  logic             cin2_reg;

  logic             valid3_reg;
  logic [WIDTH-1:0] sum3_reg;
  logic             cout3_reg;
  logic             grpg3_reg;
  logic             grpp3_reg;

  logic [WIDTH-1:0] gpre_next;
  logic [WIDTH-1:0] ppre_next;
  logic [WIDTH:0]   carry_next;
  logic [WIDTH-1:0] sum_next;

  // Whole pipeline moves together; only a blocked output stalls it.
  assign advance  = !valid3_reg | out_ready;
  assign in_ready = advance;

  // Kogge-Stone tree: level lv combines each bit with the one 2**lv below it.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_out;
    logic [WIDTH-1:0] p_out;

    if (lv == 0) begin : g_first
      assign g_in = g1_reg;
      assign p_in = p1_reg;
    end else begin : g_rest
      assign g_in = g_level[lv-1].g_out;
      assign p_in = g_level[lv-1].p_out;
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi >= (1 << lv)) begin : g_node
        gp_t node_res;
        gp_combine u_combine (
          .hi  ('{g: g_in[gi], p: p_in[gi]}),
          .lo  ('{g: g_in[gi - (1 << lv)], p: p_in[gi - (1 << lv)]}),
          .res (node_res)
        );
        assign g_out[gi] = node_res.g;
        assign p_out[gi] = node_res.p;
      end else begin : g_pass
        assign g_out[gi] = g_in[gi];
        assign p_out[gi] = p_in[gi];
      end
    end
  end

  assign gpre_next = g_level[LEVELS-1].g_out;
  assign ppre_next = g_level[LEVELS-1].p_out;

  // c[i+1] = G[i:0] | P[i:0]&cin, with c[0] = cin.
  assign carry_next = {gpre2_reg | (ppre2_reg & {WIDTH{cin2_reg}}), cin2_reg};
  assign sum_next   = p2_reg ^ carry_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_reg <= 1'b0;
      g1_reg     <= '0;
      p1_reg     <= '0;
      cin1_reg   <= 1'b0;
      valid2_reg <= 1'b0;
      gpre2_reg  <= '0;
      ppre2_reg  <= '0;
      p2_reg     <= '0;
      cin2_reg   <= 1'b0;
      valid3_reg <= 1'b0;
      sum3_reg   <= '0;
      cout3_reg  <= 1'b0;
      grpg3_reg  <= 1'b0;
      grpp3_reg  <= 1'b0;
    end else if (advance) begin
      valid1_reg <= in_valid;
      g1_reg     <= a & b;
      p1_reg     <= a ^ b;
      cin1_reg   <= cin;
      valid2_reg <= valid1_reg;
      gpre2_reg  <= gpre_next;
      ppre2_reg  <= ppre_next;
      p2_reg     <= p1_reg;
      cin2_reg   <= cin1_reg;
      valid3_reg <= valid2_reg;
      sum3_reg   <= sum_next;
      cout3_reg  <= carry_next[WIDTH];
      grpg3_reg  <= gpre2_reg[WIDTH-1];
      grpp3_reg  <= ppre2_reg[WIDTH-1];
    end
  end

  assign out_valid = valid3_reg;
  assign sum       = sum3_reg;
  assign cout      = cout3_reg;
  assign grp_g     = grpg3_reg;
  assign grp_p     = grpp3_reg;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe at WIDTH=8: directed corner cases plus random traffic.
`timescale 1ns/1ps
module tb_prefix_adder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       grp_g;
  logic       grp_p;

  typedef struct packed {
    logic       cout;
    logic       g;
    logic       p;
    logic [7:0] sum;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } stim_t;

  res_t  sb[$];
  stim_t stim_q[$];
  int    out_cycles[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .grp_g     (grp_g),
    .grp_p     (grp_p)
  );

  function automatic res_t model(input stim_t s);
    res_t       r;
    logic [8:0] full;
    logic [8:0] nocin;
    full  = {1'b0, s.a} + {1'b0, s.b} + {8'b0, s.cin};
    nocin = {1'b0, s.a} + {1'b0, s.b};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.g    = nocin[8];
    r.p    = &(s.a ^ s.b);
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.sum  = sum;
    r.cout = cout;
    r.g    = grp_g;
    r.p    = grp_p;
    return r;
  endfunction

  function automatic stim_t mk(input logic [7:0] x, input logic [7:0] y, input logic c);
    stim_t s;
    s.a   = x;
    s.b   = y;
    s.cin = c;
    return s;
  endfunction

  // Drains stim_q through the DUT, comparing every delivered result against the scoreboard.
  task automatic run_stream(input int max_cycles, input int iv_pct, input int or_pct, input string tag);
    int    n;
    stim_t s;
    res_t  exp_r;
    res_t  got;
    res_t  held_r;
    logic  held;
    n = 0;
    held = 1'b0;
    held_r = '0;
    out_cycles.delete();
    while ((stim_q.size() != 0 || sb.size() != 0) && n < max_cycles) begin
      out_ready = ($urandom_range(99) < or_pct);
      if (stim_q.size() != 0 && $urandom_range(99) < iv_pct) begin
        s = stim_q[0];
        in_valid = 1'b1;
        a = s.a;
        b = s.b;
        cin = s.cin;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      got = observed();
      if (held) begin
        n_vec++;
        if (out_valid !== 1'b1 || got !== held_r) begin
          n_err++;
          $display("FAIL %s hold: got v=%b %h, expected v=1 %h", tag, out_valid, got, held_r);
        end
      end
      held   = out_valid && !out_ready;
      held_r = got;
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_result: got %h, expected none", tag, got);
        end else begin
          exp_r = sb.pop_front();
          if (got !== exp_r) begin
            n_err++;
            $display("FAIL %s result: got {cout,g,p,sum}=%h, expected %h", tag, got, exp_r);
          end else begin
            $display("%s: sum=%h cout=%b g=%b p=%b ok", tag, got.sum, got.cout, got.g, got.p);
          end
        end
        out_cycles.push_back(n);
      end
      if (in_valid && in_ready) begin
        s = stim_q.pop_front();
        sb.push_back(model(s));
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (stim_q.size() != 0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: %0d inputs and %0d results pending, expected 0", tag, stim_q.size(), sb.size());
      stim_q.delete();
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 8'h01;
    b = 8'h01;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || observed() !== res_t'(0)) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b %h, expected v=0 000", out_valid, observed());
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_idle: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_latency();
    res_t exp_r;
    exp_r = model(mk(8'h0F, 8'h01, 1'b0));
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    cin = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL latency_accept: in_ready got %b, expected 1", in_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== (k == 3)) begin
        n_err++;
        $display("FAIL latency_valid edge %0d: got %b, expected %b", k, out_valid, (k == 3));
      end
      if (k < 3) @(posedge clk);
    end
    n_vec++;
    if (observed() !== exp_r) begin
      n_err++;
      $display("FAIL latency_result: got %h, expected %h", observed(), exp_r);
    end else begin
      $display("latency: sum=%h after 3 edges ok", sum);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_drain: out_valid got %b, expected 0", out_valid);
    end
  endtask

  task automatic test_carry();
    stim_q.push_back(mk(8'hFF, 8'h01, 1'b0));
    stim_q.push_back(mk(8'hFF, 8'h00, 1'b1));
    stim_q.push_back(mk(8'hAA, 8'h55, 1'b0));
    stim_q.push_back(mk(8'hAA, 8'h55, 1'b1));
    run_stream(50, 100, 100, "carry");
  endtask

  task automatic test_back_to_back();
    stim_q.push_back(mk(8'h01, 8'h01, 1'b0));
    stim_q.push_back(mk(8'h02, 8'h02, 1'b0));
    stim_q.push_back(mk(8'h03, 8'h03, 1'b0));
    stim_q.push_back(mk(8'h80, 8'h80, 1'b0));
    run_stream(50, 100, 100, "b2b");
    n_vec++;
    if (out_cycles.size() != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, expected 4", out_cycles.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_vec++;
        if (out_cycles[i] - out_cycles[i-1] != 1) begin
          n_err++;
          $display("FAIL b2b_spacing %0d: got gap %0d, expected 1", i, out_cycles[i] - out_cycles[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    stim_t s;
    res_t  first_r;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = mk(8'h10 + 8'(i), 8'h21, 1'(i & 1));
      in_valid = 1'b1;
      a = s.a;
      b = s.b;
      cin = s.cin;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stall_fill %0d: in_ready got %b, expected 1", i, in_ready);
      end
      sb.push_back(model(s));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    first_r = sb[0];
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== first_r) begin
        n_err++;
        $display("FAIL stall_hold %0d: got rdy=%b v=%b %h, expected rdy=0 v=1 %h",
                 k, in_ready, out_valid, observed(), first_r);
      end
      @(posedge clk);
      @(negedge clk);
    end
    $display("stall: held for 5 cycles");
    run_stream(50, 0, 100, "stall_drain");
    n_vec++;
    if (out_cycles.size() != 3) begin
      n_err++;
      $display("FAIL stall_count: got %0d results, expected 3", out_cycles.size());
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = 8'h40 + 8'(i);
      b = 8'h07;
      cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    a = 8'h33;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_stale %0d: out_valid got %b, expected 0 (sum=%h)", k, out_valid, sum);
      end
      @(posedge clk);
      @(negedge clk);
    end
    $display("reset_flush: no stale results");
    stim_q.push_back(mk(8'h5A, 8'h3C, 1'b1));
    run_stream(50, 100, 100, "after_flush");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8000; i++) begin
      stim_q.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom)));
    end
    stim_q.push_back(mk(8'hFF, 8'hFF, 1'b1));
    stim_q.push_back(mk(8'h00, 8'h00, 1'b0));
    run_stream(60000, 70, 70, "random");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_carry();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
